// File: rtl/friscv_pkg.sv
// Shared types and constants for the friscv fetch stage.
package friscv_pkg;

  localparam int         INST_WIDTH    = 32;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam logic [2:0] PROT_INST     = 3'b100;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    PURGE
  } fetch_state_t;

endpackage

// File: rtl/friscv_scfifo.sv
// Single-clock FIFO with synchronous flush; registered storage, read data is the head entry.
module friscv_scfifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [AW:0]      count_o
);

  localparam logic [AW:0] ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, rd_q;
  logic             wr_en, rd_en;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign count_o = wr_q - rd_q;
  assign wr_en   = push_i && !full_o;
  assign rd_en   = pop_i && !empty_o;
  assign data_o  = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (wr_en) wr_q <= wr_q + ONE;
      if (rd_en) rd_q <= rd_q + ONE;
    end
  end

  always_ff @(posedge aclk) begin
    if (wr_en && !flush_i) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/friscv_inst_fetcher.sv
// Instruction fetch: AXI4-lite AR/R master feeding an instruction FIFO, with jump purge.
// Optional FRISCV_FETCH_RESP_CHECK_EN stores rresp != OKAY per entry and drives inst_err.
module friscv_inst_fetcher
  import friscv_pkg::*;
#(
  parameter int          XLEN       = INST_WIDTH,
  parameter int          ADDRW      = 16,
  parameter int unsigned BOOT_ADDR  = 0,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  AXI_ID     = 8'h10
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             jump_valid,
  input  logic [ADDRW-1:0] jump_pc,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [XLEN-1:0]  inst_data,
  output logic [ADDRW-1:0] inst_pc,
  output logic             inst_err,
  output logic             arvalid,
  input  logic             arready,
  output logic [ADDRW-1:0] araddr,
  output logic [2:0]       arprot,
  output logic [7:0]       arid,
  input  logic             rvalid,
  output logic             rready,
  input  logic [XLEN-1:0]  rdata,
  input  logic [1:0]       rresp,
  input  logic [7:0]       rid
);

  localparam int CW  = $clog2(FIFO_DEPTH) + 2;
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;
`ifdef FRISCV_FETCH_RESP_CHECK_EN
  localparam int FW = 1 + ADDRW + XLEN;
`else
  localparam int FW = ADDRW + XLEN;
`endif

  fetch_state_t     state_q, state_d;
  logic             arvalid_q, arvalid_d;
  logic [ADDRW-1:0] araddr_q, araddr_d, pc_q, pc_d, rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]    ostd_q, ostd_d, purge_q, purge_d, inflight;
  logic             ar_hs, r_hs, drop, push, pop, pending, can_issue;
  logic [ADDRW-1:0] jump_tgt;
  logic [FW-1:0]    fifo_din, fifo_dout;
  logic             fifo_empty, fifo_full;
  logic [FCW-1:0]   fifo_cnt;
  logic             unused_ok;

  assign jump_tgt = {jump_pc[ADDRW-1:2], 2'b00};
  assign ar_hs    = arvalid_q && arready;
  assign r_hs     = rvalid && rready;
  assign pending  = arvalid_q && !arready;
  assign drop     = r_hs && ((purge_q != '0) || jump_valid);
  assign push     = r_hs && !drop && !fifo_full;
  assign pop      = !fifo_empty && inst_ready;
  // Every slot that will end up in the FIFO: queued, in flight, or being requested.
  assign inflight = ostd_q + CW'(fifo_cnt) + CW'(arvalid_q);

  always_comb begin
    state_d   = state_q;
    arvalid_d = arvalid_q;
    araddr_d  = araddr_q;
    pc_d      = pc_q;
    rsp_pc_d  = rsp_pc_q;
    purge_d   = purge_q;
    ostd_d    = ostd_q + CW'(ar_hs) - CW'(r_hs);
    // A jump makes everything outstanding stale, including an AR still waiting for arready.
    if (jump_valid)                     purge_d = ostd_d + CW'(pending);
    else if (r_hs && purge_q != '0)     purge_d = purge_q - CW'(1);
    if (ar_hs) arvalid_d = 1'b0;
    can_issue = !jump_valid && (!arvalid_q || arready) && (inflight < CW'(FIFO_DEPTH)) &&
                ((state_q == FETCH) || (state_q == PURGE && purge_d == '0));
    if (can_issue) begin
      arvalid_d = 1'b1;
      araddr_d  = pc_q;
      pc_d      = pc_q + ADDRW'(4);
    end
    // Responses return in order, so the PC of the next kept response is simply counted.
    if (push) rsp_pc_d = rsp_pc_q + ADDRW'(4);
    if (jump_valid) begin
      pc_d     = jump_tgt;
      rsp_pc_d = jump_tgt;
    end
    case (state_q)
      BOOT:    state_d = FETCH;
      FETCH:   if (jump_valid && purge_d != '0) state_d = PURGE;
      PURGE:   if (purge_d == '0) state_d = FETCH;
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= BOOT;
      arvalid_q <= 1'b0;
      araddr_q  <= ADDRW'(BOOT_ADDR);
      pc_q      <= ADDRW'(BOOT_ADDR);
      rsp_pc_q  <= ADDRW'(BOOT_ADDR);
      ostd_q    <= '0;
      purge_q   <= '0;
    end else begin
      state_q   <= state_d;
      arvalid_q <= arvalid_d;
      araddr_q  <= araddr_d;
      pc_q      <= pc_d;
      rsp_pc_q  <= rsp_pc_d;
      ostd_q    <= ostd_d;
      purge_q   <= purge_d;
    end
  end

`ifdef FRISCV_FETCH_RESP_CHECK_EN
  assign fifo_din  = {rresp != AXI_RESP_OKAY, rsp_pc_q, rdata};
  assign inst_err  = fifo_dout[FW-1];
  assign unused_ok = ^{rid, jump_pc[1:0]};
`else
  assign fifo_din  = {rsp_pc_q, rdata};
  assign inst_err  = 1'b0;
  assign unused_ok = ^{rid, rresp, jump_pc[1:0]};
`endif

  friscv_scfifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .aclk    (aclk),
    .aresetn (aresetn),
    .flush_i (jump_valid),
    .push_i  (push),
    .data_i  (fifo_din),
    .pop_i   (pop),
    .data_o  (fifo_dout),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_cnt)
  );

  assign arvalid    = arvalid_q;
  assign araddr     = araddr_q;
  assign arprot     = PROT_INST;
  assign arid       = AXI_ID;
  assign rready     = 1'b1;
  assign inst_valid = !fifo_empty;
  assign inst_data  = fifo_dout[XLEN-1:0];
  assign inst_pc    = fifo_dout[XLEN +: ADDRW];

endmodule

// File: tb/tb_friscv_inst_fetcher.sv
// Directed bench for friscv_inst_fetcher: in-order AXI-lite memory model, jump/purge scenarios.
module tb_friscv_inst_fetcher;

`ifdef FRISCV_FETCH_RESP_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        jump_valid = 1'b0;
  logic [15:0] jump_pc = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [15:0] inst_pc;
  logic        inst_err;
  logic        arvalid, arready;
  logic [15:0] araddr;
  logic [2:0]  arprot;
  logic [7:0]  arid;
  logic        rvalid = 1'b0;
  logic        rready;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic [7:0]  rid = '0;

  always #5 aclk = ~aclk;

  friscv_inst_fetcher #(
    .XLEN(32), .ADDRW(16), .BOOT_ADDR(0), .FIFO_DEPTH(4), .AXI_ID(8'h10)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .jump_valid(jump_valid), .jump_pc(jump_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
    .inst_pc(inst_pc), .inst_err(inst_err), .arvalid(arvalid), .arready(arready),
    .araddr(araddr), .arprot(arprot), .arid(arid), .rvalid(rvalid), .rready(rready),
    .rdata(rdata), .rresp(rresp), .rid(rid)
  );

  // Memory model: in-order responses, lat cycles after the AR handshake.
  logic        arready_en = 1'b1;
  int          lat = 1;
  logic [15:0] err_addr = 16'hFFFF;
  assign arready = arready_en;

  logic [15:0] q_addr[$];
  int          q_cyc[$];
  int          cyc = 0;
  int          ar_cnt = 0;
  int          stab_viol = 0;
  logic        prev_pend = 1'b0;
  logic [15:0] prev_addr = '0;
  logic [15:0] a;
  logic [15:0] got_pc[$];
  logic [31:0] got_data[$];
  logic        got_err[$];
  int          got_cyc[$];

  always @(negedge aclk) begin
    cyc++;
    if (!aresetn) begin
      q_addr.delete(); q_cyc.delete();
      got_pc.delete(); got_data.delete(); got_err.delete(); got_cyc.delete();
      rvalid = 1'b0; ar_cnt = 0; prev_pend = 1'b0;
    end else begin
      if (prev_pend && (!arvalid || araddr !== prev_addr)) stab_viol++;
      prev_pend = arvalid && !arready;
      prev_addr = araddr;
      if (inst_valid && inst_ready) begin
        got_pc.push_back(inst_pc); got_data.push_back(inst_data);
        got_err.push_back(inst_err); got_cyc.push_back(cyc);
      end
      rvalid = 1'b0;
      rresp  = 2'b00;
      if (q_addr.size() > 0 && (cyc - q_cyc[0]) >= lat) begin
        a = q_addr.pop_front();
        void'(q_cyc.pop_front());
        rvalid = 1'b1;
        rdata  = 32'hC0DE_0000 | {16'h0, a};
        rresp  = (a == err_addr) ? 2'b10 : 2'b00;
      end
      if (arvalid && arready) begin
        q_addr.push_back(araddr);
        q_cyc.push_back(cyc);
        ar_cnt++;
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic jump(input logic [15:0] tgt);
    jump_valid = 1'b1;
    jump_pc    = tgt;
    step(1);
    jump_valid = 1'b0;
  endtask

  task automatic restart(input int l);
    aresetn = 1'b0;
    step(2);
    lat        = l;
    inst_ready = 1'b1;
    arready_en = 1'b1;
    aresetn    = 1'b1;
  endtask

  function automatic logic [31:0] gpc(input int i);
    if (i < got_pc.size()) return {16'h0, got_pc[i]};
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] gdat(input int i);
    if (i < got_data.size()) return got_data[i];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] gerr(input int i);
    if (i < got_err.size()) return {31'h0, got_err[i]};
    return 32'hDEAD_BEEF;
  endfunction

  int          bad;
  int          n_after;
  logic [15:0] hold_addr;
  logic [15:0] hold_pc;

  initial begin
    // Reset state
    inst_ready = 1'b1;
    step(2);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_rready", rready, 1);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_arprot", arprot, 3'b100);
    chk("rst_arid", arid, 8'h10);
    aresetn = 1'b1;

    // Streaming, 1-cycle R latency: first pop 4 edges after release, then 1/cycle
    step(25);
    chk("t1_count", got_pc.size(), 21);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t1_pc%0d", i), gpc(i), 4 * i);
      chk($sformatf("t1_data%0d", i), gdat(i), 32'hC0DE_0000 | (4 * i));
    end
    chk("t1_rate", got_cyc[7] - got_cyc[0], 7);
    chk("t1_err", gerr(2), 0);

    // Consumer stall: exactly FIFO_DEPTH words beyond what was consumed
    inst_ready = 1'b0;
    step(3);
    hold_pc = inst_pc;
    step(17);
    chk("t2_ar_total", ar_cnt, 25);
    chk("t2_arvalid", arvalid, 0);
    chk("t2_inst_valid", inst_valid, 1);
    chk("t2_head_pc", inst_pc, 16'h54);
    chk("t2_hold_pc", inst_pc, hold_pc);
    inst_ready = 1'b1;
    step(20);
    bad = -1;
    for (int i = 0; i < got_pc.size(); i++)
      if (bad < 0 && (gpc(i) !== 4 * i || gdat(i) !== (32'hC0DE_0000 | (4 * i)))) bad = i;
    chk("t2_seq_first_bad", bad, -1);
    chk("t2_resumed", got_pc.size() > 40, 1);

    // AR stalled by arready=0, jump to 0x100 while the AR is pending
    arready_en = 1'b0;
    step(1);
    hold_addr = araddr;
    chk("t3_pending", arvalid, 1);
    step(2);
    jump(16'h100);
    n_after = got_pc.size();
    chk("t3_flush_valid", inst_valid, 0);
    chk("t3_hold_arvalid", arvalid, 1);
    chk("t3_hold_araddr", araddr, hold_addr);
    step(1);
    arready_en = 1'b1;
    step(15);
    chk("t3_first_pc", gpc(n_after), 16'h100);
    chk("t3_first_data", gdat(n_after), 32'hC0DE_0100);
    chk("t3_second_pc", gpc(n_after + 1), 16'h104);

    // Mid-operation reset, then 3 outstanding ARs at latency 4 and jump to 0x40
    aresetn = 1'b0;
    step(1);
    chk("t4_rst_inst_valid", inst_valid, 0);
    chk("t4_rst_arvalid", arvalid, 0);
    restart(4);
    step(4);
    jump(16'h43);
    chk("t4_ostd", ar_cnt, 3);
    chk("t4_no_issue", arvalid, 0);
    step(3);
    chk("t4_purging", arvalid, 0);
    chk("t4_purge_empty", inst_valid, 0);
    step(1);
    chk("t4_refetch_valid", arvalid, 1);
    chk("t4_refetch_addr", araddr, 16'h40);
    step(20);
    chk("t4_first_pc", gpc(0), 16'h40);
    chk("t4_second_pc", gpc(1), 16'h44);

    // Jump on the same edge as an R handshake and a pop
    restart(1);
    step(8);
    jump(16'h200);
    chk("t5_pops", got_pc.size(), 5);
    chk("t5_last_pop", gpc(4), 16'h10);
    chk("t5_no_issue", arvalid, 0);
    step(1);
    chk("t5_refetch_valid", arvalid, 1);
    chk("t5_refetch_addr", araddr, 16'h200);
    step(10);
    chk("t5_first_pc", gpc(5), 16'h200);
    chk("t5_second_pc", gpc(6), 16'h204);

    // SLVERR on PC 0x8
    err_addr = 16'h0008;
    restart(1);
    step(15);
    chk("t6_pc2", gpc(2), 16'h8);
    chk("t6_err1", gerr(1), 0);
    chk("t6_err2", gerr(2), {31'h0, EXP_ERR});
    chk("t6_err3", gerr(3), 0);

    chk("ar_stability", stab_viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
